// File: rtl/vga_sync_gen.sv
// VGA timing generator: a clk-to-pixel divider drives x/y raster counters.
// The sync and blank outputs come from flops so they stay aligned with x/y.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY   = 160,
  parameter int unsigned H_FRONT     = 4,
  parameter int unsigned H_SYNC      = 24,
  parameter int unsigned H_BACK      = 12,
  parameter int unsigned V_DISPLAY   = 120,
  parameter int unsigned V_FRONT     = 3,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 8,
  parameter int unsigned PIX_DIV     = 4,
  parameter int unsigned SYNC_POL    = 0,
  parameter int unsigned X_BIT_WIDTH = 10,
  parameter int unsigned Y_BIT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [X_BIT_WIDTH-1:0] x,
  output logic [Y_BIT_WIDTH-1:0] y,
  output logic                   video_on,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   p_tick,
  output logic                   line_end,
  output logic                   frame_end
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Raster boundaries sized to the counters so all compares are unsigned at counter width.
  localparam logic [X_BIT_WIDTH-1:0] HLast      = X_BIT_WIDTH'(H_TOTAL - 1);
  localparam logic [X_BIT_WIDTH-1:0] HDispEnd   = X_BIT_WIDTH'(H_DISPLAY);
  localparam logic [X_BIT_WIDTH-1:0] HSyncFirst = X_BIT_WIDTH'(H_DISPLAY + H_FRONT);
  localparam logic [X_BIT_WIDTH-1:0] HSyncLast  = X_BIT_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [Y_BIT_WIDTH-1:0] VLast      = Y_BIT_WIDTH'(V_TOTAL - 1);
  localparam logic [Y_BIT_WIDTH-1:0] VDispEnd   = Y_BIT_WIDTH'(V_DISPLAY);
  localparam logic [Y_BIT_WIDTH-1:0] VSyncFirst = Y_BIT_WIDTH'(V_DISPLAY + V_FRONT);
  localparam logic [Y_BIT_WIDTH-1:0] VSyncLast  = Y_BIT_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam int unsigned       DivW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DivW-1:0]   DivLast = DivW'(PIX_DIV - 1);
  localparam logic              SyncAct = (SYNC_POL != 0);

  // Reject parameter sets the counters cannot represent.
  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: PIX_DIV must be at least 1");
  end
  if (V_FRONT < 2) begin : g_bad_vfront
    $error("vga_sync_gen: V_FRONT must be at least 2");
  end
  if (((H_TOTAL - 1) >> X_BIT_WIDTH) != 0) begin : g_bad_xw
    $error("vga_sync_gen: X_BIT_WIDTH too small for H_TOTAL");
  end
  if (((V_TOTAL - 1) >> Y_BIT_WIDTH) != 0) begin : g_bad_yw
    $error("vga_sync_gen: Y_BIT_WIDTH too small for V_TOTAL");
  end

  logic [DivW-1:0]        div_q, div_d;
  logic [X_BIT_WIDTH-1:0] x_q, x_d;
  logic [Y_BIT_WIDTH-1:0] y_q, y_d;
  logic                   video_on_q, video_on_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   div_last;

  // Strobes: gated by reset so nothing pulses while the block is held.
  always_comb begin
    div_last  = (div_q == DivLast);
    p_tick    = reset & div_last;
    line_end  = p_tick & (x_q == HLast);
    frame_end = line_end & (y_q == VLast);
  end

  // Next-state for the divider and the raster counters.
  always_comb begin
    div_d = div_last ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (p_tick) begin
      if (x_q == HLast) begin
        x_d = '0;
        y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Decode the upcoming position so the registered outputs match x/y after the edge.
  always_comb begin
    video_on_d = (x_d < HDispEnd) && (y_d < VDispEnd);
    hsync_d    = ((x_d >= HSyncFirst) && (x_d <= HSyncLast)) ? SyncAct : ~SyncAct;
    vsync_d    = ((y_d >= VSyncFirst) && (y_d <= VSyncLast)) ? SyncAct : ~SyncAct;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      video_on_q <= 1'b0;
      hsync_q    <= ~SyncAct;
      vsync_q    <= ~SyncAct;
    end else begin
      div_q      <= div_d;
      x_q        <= x_d;
      y_q        <= y_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign video_on = video_on_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (defaults, PIX_DIV=1, small active-high raster)
// checked every cycle against a position model derived from the count of running edges.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       le;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a, reset_b, reset_c;

  logic [9:0] xa, ya, xb, yb;
  logic [3:0] xc, yc;
  logic von_a, hs_a, vs_a, pt_a, le_a, fe_a;
  logic von_b, hs_b, vs_b, pt_b, le_b, fe_b;
  logic von_c, hs_c, vs_c, pt_c, le_c, fe_c;

  int          n_cmp  = 0;
  int          n_fail = 0;
  longint unsigned ka = 0, kb = 0, kc = 0, cyc = 0, last_fe_b = 0;
  int          n_per_b = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_a (
    .clk(clk), .reset(reset_a), .x(xa), .y(ya), .video_on(von_a), .hsync(hs_a),
    .vsync(vs_a), .p_tick(pt_a), .line_end(le_a), .frame_end(fe_a)
  );

  vga_sync_gen #(.PIX_DIV(1)) u_b (
    .clk(clk), .reset(reset_b), .x(xb), .y(yb), .video_on(von_b), .hsync(hs_b),
    .vsync(vs_b), .p_tick(pt_b), .line_end(le_b), .frame_end(fe_b)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(1), .V_BACK(2),
    .PIX_DIV(3), .SYNC_POL(1), .X_BIT_WIDTH(4), .Y_BIT_WIDTH(4)
  ) u_c (
    .clk(clk), .reset(reset_c), .x(xc), .y(yc), .video_on(von_c), .hsync(hs_c),
    .vsync(vs_c), .p_tick(pt_c), .line_end(le_c), .frame_end(fe_c)
  );

  // Expected outputs after k running edges: pixel index is k/div, raster position follows.
  function automatic exp_t model(input int unsigned hd, hf, hsw, hb, vd, vf, vsw, vb, pd, pol,
                                 input logic rst_n, input longint unsigned k);
    exp_t e;
    longint unsigned ht, vt, p, xx, yy;
    e = '0;
    if (!rst_n) begin
      e.hs = (pol == 0);
      e.vs = (pol == 0);
      return e;
    end
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    p  = k / pd;
    xx = p % ht;
    yy = (p / ht) % vt;
    e.x   = 10'(xx);
    e.y   = 10'(yy);
    e.von = (xx < hd) && (yy < vd);
    e.hs  = ((xx >= hd + hf) && (xx < hd + hf + hsw)) ? (pol != 0) : (pol == 0);
    e.vs  = ((yy >= vd + vf) && (yy < vd + vf + vsw)) ? (pol != 0) : (pol == 0);
    e.pt  = ((k % pd) == pd - 1);
    e.le  = e.pt && (xx == ht - 1);
    e.fe  = e.le && (yy == vt - 1);
    return e;
  endfunction

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic chk(input string name, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d von=%b hs=%b vs=%b pt=%b le=%b fe=%b, want x=%0d y=%0d von=%b hs=%b vs=%b pt=%b le=%b fe=%b",
               name, got.x, got.y, got.von, got.hs, got.vs, got.pt, got.le, got.fe,
               want.x, want.y, want.von, want.hs, want.vs, want.pt, want.le, want.fe);
      if (n_fail >= 500) summary_and_finish();
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Edge counters plus the per-cycle comparison against the model.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ka  <= reset_a ? ka + 1 : 0;
    kb  <= reset_b ? kb + 1 : 0;
    kc  <= reset_c ? kc + 1 : 0;
    #1;
    chk("dut_a", {xa, ya, von_a, hs_a, vs_a, pt_a, le_a, fe_a},
        model(160, 4, 24, 12, 120, 3, 2, 8, 4, 0, reset_a, ka));
    chk("dut_b", {xb, yb, von_b, hs_b, vs_b, pt_b, le_b, fe_b},
        model(160, 4, 24, 12, 120, 3, 2, 8, 1, 0, reset_b, kb));
    chk("dut_c", {6'd0, xc, 6'd0, yc, von_c, hs_c, vs_c, pt_c, le_c, fe_c},
        model(8, 2, 3, 2, 4, 2, 1, 2, 3, 1, reset_c, kc));
    if (fe_b) begin
      if (last_fe_b != 0) begin
        chk_val("b_frame_period", 32'(cyc - last_fe_b), 32'd26600);
        n_per_b <= n_per_b + 1;
      end
      last_fe_b <= cyc;
    end
  end

  // Advance until the chosen instance has seen 'target' running edges (bounded).
  task automatic wait_k(input int which, input longint unsigned target);
    int guard;
    longint unsigned cur;
    guard = 0;
    cur = (which == 0) ? ka : kb;
    while (cur != target && guard < 70000) begin
      @(posedge clk);
      #2;
      guard++;
      cur = (which == 0) ? ka : kb;
    end
    if (cur != target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_timeout: got k=%0d, want k=%0d", cur, target);
    end
  endtask

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;
    reset_c = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk_val("rst_x", 32'(xa), 0);
    chk_val("rst_y", 32'(ya), 0);
    chk_val("rst_von", 32'(von_a), 0);
    chk_val("rst_hsync", 32'(hs_a), 1);
    chk_val("rst_vsync", 32'(vs_a), 1);
    chk_val("rst_ptick", 32'(pt_a), 0);
    chk_val("rst_c_hsync", 32'(hs_c), 0);

    @(negedge clk);
    reset_a = 1'b1;
    reset_b = 1'b1;
    reset_c = 1'b1;

    @(posedge clk);
    #2;
    chk_val("first_von", 32'(von_a), 1);
    chk_val("first_ptick", 32'(pt_a), 0);

    wait_k(0, 3);
    chk_val("tick3_ptick", 32'(pt_a), 1);
    chk_val("tick3_x", 32'(xa), 0);
    wait_k(0, 4);
    chk_val("k4_x", 32'(xa), 1);
    chk_val("k4_ptick", 32'(pt_a), 0);
    wait_k(0, 636);
    chk_val("x159_von", 32'(von_a), 1);
    wait_k(0, 640);
    chk_val("x160_x", 32'(xa), 160);
    chk_val("x160_von", 32'(von_a), 0);
    wait_k(0, 656);
    chk_val("x164_hsync", 32'(hs_a), 0);
    wait_k(0, 748);
    chk_val("x187_hsync", 32'(hs_a), 0);
    wait_k(0, 752);
    chk_val("x188_hsync", 32'(hs_a), 1);
    wait_k(0, 8799);
    chk_val("le_x", 32'(xa), 199);
    chk_val("le_y", 32'(ya), 10);
    chk_val("le_pulse", 32'(le_a), 1);
    chk_val("le_no_fe", 32'(fe_a), 0);
    wait_k(0, 8800);
    chk_val("le_after_pulse", 32'(le_a), 0);
    chk_val("le_after_x", 32'(xa), 0);
    chk_val("le_after_y", 32'(ya), 11);

    wait_k(1, 24200);
    chk_val("b_line121_y", 32'(yb), 121);
    chk_val("b_line121_von", 32'(von_b), 0);
    wait_k(1, 24600);
    chk_val("b_y123_vsync", 32'(vs_b), 0);
    wait_k(1, 25000);
    chk_val("b_y125_vsync", 32'(vs_b), 1);
    wait_k(1, 26599);
    chk_val("b_fe_x", 32'(xb), 199);
    chk_val("b_fe_y", 32'(yb), 132);
    chk_val("b_fe_pulse", 32'(fe_b), 1);
    wait_k(1, 26600);
    chk_val("b_wrap_x", 32'(xb), 0);
    chk_val("b_wrap_y", 32'(yb), 0);
    chk_val("b_wrap_fe", 32'(fe_b), 0);

    wait_k(0, 48200);
    chk_val("mid_x", 32'(xa), 50);
    chk_val("mid_y", 32'(ya), 60);
    @(negedge clk);
    reset_a = 1'b0;
    @(posedge clk);
    #2;
    chk_val("mid_rst_x", 32'(xa), 0);
    chk_val("mid_rst_y", 32'(ya), 0);
    chk_val("mid_rst_von", 32'(von_a), 0);
    chk_val("mid_rst_hsync", 32'(hs_a), 1);
    chk_val("mid_rst_vsync", 32'(vs_a), 1);
    chk_val("mid_rst_ptick", 32'(pt_a), 0);
    @(negedge clk);
    reset_a = 1'b1;

    wait_k(1, 53199);
    chk_val("b_fe2_pulse", 32'(fe_b), 1);
    repeat (3) @(posedge clk);
    #2;
    chk_val("b_period_count", 32'(n_per_b), 1);

    summary_and_finish();
  end

endmodule
